// File: rtl/opc2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opc2_pkg
// Brief    : Shared types and constants for the OPC2 boot loader.
// Revision : 1.0 - initial release
// ============================================================================
package opc2_pkg;

    localparam int OPC2_AW = 11;
    localparam int OPC2_DW = 8;
    localparam logic [OPC2_AW-1:0] OPC2_RESET_VECTOR = 11'h100;

    typedef enum logic [2:0] {
        S_AHI  = 3'd0,
        S_ALO  = 3'd1,
        S_LHI  = 3'd2,
        S_LLO  = 3'd3,
        S_DATA = 3'd4,
        S_CSUM = 3'd5,
        S_RUN  = 3'd6,
        S_ERR  = 3'd7
    } opc2_state_t;

endpackage : opc2_pkg
`default_nettype wire

// File: rtl/opc2_loader.sv
`default_nettype none
// ============================================================================
// Module   : opc2_loader
// Brief    : Framed byte-stream loader that fills OPC2 memory, checks the
//            payload checksum and then releases the CPU reset.
// Revision : 1.0 - initial release
// ============================================================================
module opc2_loader
    import opc2_pkg::*;
#(
    parameter bit BYPASS = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPC2_DW-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OPC2_AW-1:0] mem_addr,
    output logic [OPC2_DW-1:0] mem_data,
    output logic               mem_we,
    output logic               cpu_reset_b,
    output logic               done,
    output logic               error
);

    opc2_state_t        state;
    logic [OPC2_AW-1:0] addr;
    logic [OPC2_AW-1:0] remaining;
    logic [OPC2_DW-1:0] csum;
    logic [OPC2_AW-1:0] hdr_len;
    logic               accept;

    assign in_ready = !reset && (state != S_RUN) && (state != S_ERR);
    assign accept   = in_valid && in_ready;
    assign hdr_len  = {remaining[OPC2_AW-1:OPC2_DW], in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_AHI;
            addr        <= '0;
            remaining   <= '0;
            csum        <= '0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_we      <= 1'b0;
            cpu_reset_b <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            // Status outputs follow the state one cycle later, so the last
            // payload write always retires before the CPU is released.
            cpu_reset_b <= (state == S_RUN);
            done        <= (state == S_RUN);
            error       <= (state == S_ERR);

            if (BYPASS) begin
                state <= S_RUN;
            end else begin
                case (state)
                    S_AHI: begin
                        csum <= '0;
                        if (accept) begin
                            addr  <= {in_data[OPC2_AW-OPC2_DW-1:0], {OPC2_DW{1'b0}}};
                            state <= S_ALO;
                        end
                    end
                    S_ALO: begin
                        if (accept) begin
                            addr[OPC2_DW-1:0] <= in_data;
                            state             <= S_LHI;
                        end
                    end
                    S_LHI: begin
                        if (accept) begin
                            remaining <= {in_data[OPC2_AW-OPC2_DW-1:0], {OPC2_DW{1'b0}}};
                            state     <= S_LLO;
                        end
                    end
                    S_LLO: begin
                        if (accept) begin
                            remaining <= hdr_len;
                            state     <= (hdr_len == '0) ? S_CSUM : S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            mem_addr  <= addr;
                            mem_data  <= in_data;
                            mem_we    <= 1'b1;
                            addr      <= addr + 1'b1;
                            csum      <= csum + in_data;
                            remaining <= remaining - 1'b1;
                            if (remaining == {{(OPC2_AW-1){1'b0}}, 1'b1}) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (accept) begin
                            state <= (in_data == csum) ? S_RUN : S_ERR;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule : opc2_loader
`default_nettype wire
